// File: rtl/axis_skid_buffer.sv
// AXI-Stream full register slice with a main + skid buffer.
// Every output is a flop; no comb path crosses the slice.
module axis_skid_buffer #(
    parameter int AXIS_DATA_WIDTH = 64
) (
    input  logic                         clk_i,
    input  logic                         arstn_i,
    input  logic                         s_axis_tvalid,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic                         m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [1:0]                   occupancy_o
);

    localparam int SW = AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic                       s_rdy_q, s_rdy_d;
    logic                       m_vld_q, m_vld_d;
    logic [1:0]                 occ_q, occ_d;
    logic [AXIS_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [SW-1:0]              m_strb_q, m_strb_d;
    logic                       m_last_q, m_last_d;
    logic [AXIS_DATA_WIDTH-1:0] k_data_q, k_data_d;
    logic [SW-1:0]              k_strb_q, k_strb_d;
    logic                       k_last_q, k_last_d;
    logic                       s_fire;

    // s_rdy_q stays low for one cycle after reset release, so gate with it
    assign s_fire = s_axis_tvalid & s_rdy_q;

    // Next-state, buffer moves and registered handshake outputs
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_strb_d = m_strb_q;
        m_last_d = m_last_q;
        k_data_d = k_data_q;
        k_strb_d = k_strb_q;
        k_last_d = k_last_q;
        unique case (state_q)
            EMPTY: begin
                if (s_fire) begin
                    m_data_d = s_axis_tdata;
                    m_strb_d = s_axis_tstrb;
                    m_last_d = s_axis_tlast;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (s_fire && m_axis_tready) begin
                    m_data_d = s_axis_tdata;
                    m_strb_d = s_axis_tstrb;
                    m_last_d = s_axis_tlast;
                end else if (s_fire) begin
                    k_data_d = s_axis_tdata;
                    k_strb_d = s_axis_tstrb;
                    k_last_d = s_axis_tlast;
                    state_d  = FULL;
                end else if (m_axis_tready) begin
                    state_d  = EMPTY;
                end
            end
            FULL: begin
                if (m_axis_tready) begin
                    m_data_d = k_data_q;
                    m_strb_d = k_strb_q;
                    m_last_d = k_last_q;
                    state_d  = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        s_rdy_d = (state_d != FULL);
        m_vld_d = (state_d != EMPTY);
        occ_d   = (state_d == FULL) ? 2'd2 :
                  (state_d == BUSY) ? 2'd1 : 2'd0;
    end

    // State and buffer registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= EMPTY;
            s_rdy_q  <= 1'b0;
            m_vld_q  <= 1'b0;
            occ_q    <= 2'd0;
            m_data_q <= '0;
            m_strb_q <= '0;
            m_last_q <= 1'b0;
            k_data_q <= '0;
            k_strb_q <= '0;
            k_last_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_rdy_q  <= s_rdy_d;
            m_vld_q  <= m_vld_d;
            occ_q    <= occ_d;
            m_data_q <= m_data_d;
            m_strb_q <= m_strb_d;
            m_last_q <= m_last_d;
            k_data_q <= k_data_d;
            k_strb_q <= k_strb_d;
            k_last_q <= k_last_d;
        end
    end

    assign s_axis_tready = s_rdy_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tstrb  = m_strb_q;
    assign m_axis_tlast  = m_last_q;
    assign occupancy_o   = occ_q;

endmodule

// File: doc/axis_skid_buffer.md
Name: axis_skid_buffer

Overview:
- Full AXI-Stream register slice: registers the forward path (tvalid/tdata/tstrb/tlast) and the backward path (tready).
- No combinational path from any m_axis input to any s_axis output, or from any s_axis input to any m_axis output.
- Uses a 2-entry main+skid buffer to sustain one beat per clock.
- Inserted between stream stages to close timing on long tready nets.

Parameters:
- AXIS_DATA_WIDTH, 64, tdata width in bits; must be a multiple of 8. tstrb width is AXIS_DATA_WIDTH/8.

Ports:
- clk_i  input  1  clock; all logic on rising edge
- arstn_i  input  1  asynchronous active-low reset
- s_axis_tvalid  input  1  upstream beat valid
- s_axis_tdata  input  AXIS_DATA_WIDTH  upstream data
- s_axis_tstrb  input  AXIS_DATA_WIDTH/8  upstream byte strobes
- s_axis_tlast  input  1  upstream end of packet
- s_axis_tready  output  1  slice can accept a beat; driven directly from a flop
- m_axis_tvalid  output  1  downstream beat valid; driven directly from a flop
- m_axis_tdata  output  AXIS_DATA_WIDTH  downstream data; driven directly from a flop
- m_axis_tstrb  output  AXIS_DATA_WIDTH/8  downstream strobes; driven directly from a flop
- m_axis_tlast  output  1  downstream end of packet; driven directly from a flop
- m_axis_tready  input  1  downstream ready
- occupancy_o  output  2  beats held: 0, 1 or 2

Behaviour:
- Interface (decided): one clock, clk_i; reset arstn_i is asynchronous, active-low.
- Reset (arstn_i=0), asserted asynchronously:
  - state=EMPTY; m_axis_tvalid=0; m_axis_tdata/tstrb/tlast=0; skid registers=0.
  - s_axis_tready=0; occupancy_o=0.
  - Deassertion is treated as synchronous: s_axis_tready goes to 1 on the first rising edge after arstn_i=1.
- Handshake: a transfer occurs on any edge where tvalid&tready=1 on that interface. An s beat accepted at edge N appears on m_axis at edge N (visible cycle N+1). Latency 1 when empty.
- State machine. Main register drives m_axis_*; the skid register holds one overflow beat.
  - EMPTY: occupancy 0, m_tvalid=0, s_tready=1.
    - s_tvalid -> main<=s beat, go to BUSY.
  - BUSY: occupancy 1, m_tvalid=1, s_tready=1.
    - s_tvalid & m_tready -> main<=s beat, stay BUSY (full throughput).
    - s_tvalid & !m_tready -> skid<=s beat, go to FULL, s_tready<=0.
    - !s_tvalid & m_tready -> m_tvalid<=0, go to EMPTY.
    - neither -> hold.
  - FULL: occupancy 2, m_tvalid=1, s_tready=0; s_axis inputs ignored.
    - m_tready -> main<=skid, go to BUSY, s_tready<=1.
    - else hold.
- AXIS rule: while m_tvalid=1 and m_tready=0, m_axis_tdata/tstrb/tlast stay stable.
- Beat ordering preserved. No beat dropped or duplicated. tlast and tstrb travel with their data bit-exact.
- s_axis_tvalid while s_axis_tready=0 has no effect.
- Reset mid-operation: both held beats are discarded and outputs return to reset values immediately; no partial packet recovery.
- No state where s_tready=1 with occupancy 2, or m_tvalid=0 with occupancy >0.

Test Plan:
- Reset: hold arstn_i=0 for 5 cycles with s_tvalid=1 -> m_tvalid=0, s_tready=0, occupancy_o=0. First edge after release -> s_tready=1.
- Streaming: m_tready=1; send 16 beats tdata=0..15, tstrb=0xFF, tlast on beat 15 -> m_axis emits 0..15 back-to-back, one cycle after input. Beat 15 has tlast=1. occupancy_o stays 1.
- Backpressure fill: BUSY holding 0xA; drop m_tready and present 0xB -> occupancy_o=2, s_tready=0 next cycle. m_tdata held at 0xA. Present 0xC while FULL -> 0xC not accepted.
- Drain: from FULL (0xA, 0xB), raise m_tready for 2 cycles -> outputs 0xA then 0xB. s_tready returns to 1 after the first beat. 0xC is accepted once s_tready=1 and emitted third.
- Random: 10000 beats, random s_tvalid and m_tready at 50% each -> scoreboard matches exactly (data/strb/last). s_tready never depends combinationally on m_tready (toggle m_tready mid-cycle -> s_tready unchanged).
- Async reset while FULL -> outputs cleared immediately without a clock edge. After release, the first new beat 0x55 appears alone.
